// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared CPU types for the branch target buffer
// Purpose: 2-bit direction counter encoding and the BTB entry layout.
// Ports:   none (package).
package branch_target_buffer_pkg;

  // Tag and target fields are sized for the widest supported PC; the BTB
  // zero-extends narrower values on write so compares stay exact.
  localparam int btb_max_width = 64;

  typedef logic [btb_max_width-1:0] btb_addr_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_e;

  typedef struct packed {
    logic      valid;
    btb_addr_t tag;
    btb_addr_t target;
    ctr_e      ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// rtl/branch_target_buffer_sat_counter2.sv - 2-bit saturating direction counter next state
// Purpose: combinational next-state for one 2-bit branch direction counter.
// Ports:   state (current), taken (resolved direction),
//          force_strong_taken (unconditional jump), next_state (result).
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  ctr_e state,
  input  logic taken,
  input  logic force_strong_taken,
  output ctr_e next_state
);

  always_comb begin
    next_state = state;
    if (force_strong_taken) begin
      next_state = STRONG_T;
    end else if (taken) begin
      if (state != STRONG_T) next_state = ctr_e'(state + 2'd1);
    end else begin
      if (state != STRONG_NT) next_state = ctr_e'(state - 2'd1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit counters
// Purpose: zero-latency fetch prediction plus resolved-branch training.
// Ports:   clk_i, reset_i (sync, active-high);
//          fetch_pc_i -> predict_hit_o, predict_taken_o, predict_target_o;
//          update_valid_i, update_pc_i, update_taken_i, update_is_jump_i,
//          update_target_i (training); hit_count_o (wrapping hit counter).
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int width_p   = 32,
  parameter int entries_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] fetch_pc_i,
  output logic               predict_hit_o,
  output logic               predict_taken_o,
  output logic [width_p-1:0] predict_target_o,
  input  logic               update_valid_i,
  input  logic [width_p-1:0] update_pc_i,
  input  logic               update_taken_i,
  input  logic               update_is_jump_i,
  input  logic [width_p-1:0] update_target_i,
  output logic [31:0]        hit_count_o
);

  localparam int idx_w = $clog2(entries_p);
  localparam int tag_w = width_p - 2 - idx_w;

  btb_entry_t mem [entries_p];

  logic [idx_w-1:0] fetch_idx;
  logic [idx_w-1:0] upd_idx;
  logic [tag_w-1:0] fetch_tag;
  logic [tag_w-1:0] upd_tag;
  btb_entry_t       fetch_e;
  btb_entry_t       upd_e;
  logic             upd_hit;
  ctr_e             ctr_next;
  logic             unused_bits;

  assign fetch_idx = fetch_pc_i[2 +: idx_w];
  assign fetch_tag = fetch_pc_i[width_p-1 -: tag_w];
  assign upd_idx   = update_pc_i[2 +: idx_w];
  assign upd_tag   = update_pc_i[width_p-1 -: tag_w];

  // Both ports read the array before the edge, so a same-cycle update is
  // never visible to the lookup (no bypass).
  assign fetch_e = mem[fetch_idx];
  assign upd_e   = mem[upd_idx];

  assign predict_hit_o    = fetch_e.valid && (fetch_e.tag == btb_addr_t'(fetch_tag));
  assign predict_taken_o  = predict_hit_o && fetch_e.ctr[1];
  assign predict_target_o = predict_taken_o ? fetch_e.target[width_p-1:0]
                                            : fetch_pc_i + width_p'(4);

  assign upd_hit = upd_e.valid && (upd_e.tag == btb_addr_t'(upd_tag));

  // Byte-offset bits and the padded high target bits carry no information.
  assign unused_bits = ^{update_pc_i[1:0], fetch_e.target, upd_e.target};

  sat_counter2 u_sat_counter2 (
    .state              (upd_e.ctr),
    .taken              (update_taken_i),
    .force_strong_taken (update_is_jump_i),
    .next_state         (ctr_next)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < entries_p; i++) mem[i].valid <= 1'b0;
      hit_count_o <= '0;
    end else begin
      if (predict_hit_o) hit_count_o <= hit_count_o + 32'd1;
      if (update_valid_i) begin
        if (upd_hit) begin
          mem[upd_idx].ctr <= ctr_next;
          if (update_taken_i) mem[upd_idx].target <= btb_addr_t'(update_target_i);
        end else if (update_taken_i) begin
          // Taken miss allocates over any occupant; not-taken misses are dropped.
          mem[upd_idx].valid  <= 1'b1;
          mem[upd_idx].tag    <= btb_addr_t'(upd_tag);
          mem[upd_idx].target <= btb_addr_t'(update_target_i);
          mem[upd_idx].ctr    <= update_is_jump_i ? STRONG_T : WEAK_T;
        end
      end
    end
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The module SHALL have parameter width_p, default 32, giving the PC/target width in bits.
REQ-002 The module SHALL have parameter entries_p, default 16, giving the number of direct-mapped entries; it is a power of two, at least 2.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port fetch_pc_i, input, width_p bits: PC of the instruction being fetched.
REQ-006 The module SHALL have port predict_hit_o, output, 1 bit: an entry is valid for fetch_pc_i and its tag matches.
REQ-007 The module SHALL have port predict_taken_o, output, 1 bit: predict redirect.
REQ-008 The module SHALL have port predict_target_o, output, width_p bits: the next fetch PC.
REQ-009 The module SHALL have port update_valid_i, input, 1 bit: a resolved control-flow instruction is presented this cycle.
REQ-010 The module SHALL have port update_pc_i, input, width_p bits: the address of the resolved instruction (not PC+4).
REQ-011 The module SHALL have port update_taken_i, input, 1 bit: resolved direction.
REQ-012 The module SHALL have port update_is_jump_i, input, 1 bit: the resolved instruction is JAL or JALR.
REQ-013 The module SHALL have port update_target_i, input, width_p bits: the resolved target from the execute-stage branch target logic.
REQ-014 The module SHALL have port hit_count_o, output, 32 bits: number of cycles in which predict_hit_o was 1 (wraps).

Function
REQ-015 Index SHALL be pc[2+log2(entries_p)-1:2]; tag SHALL be pc[width_p-1:2+log2(entries_p)]; pc[1:0] SHALL be ignored.
REQ-016 Each entry SHALL hold: valid, tag, target (width_p bits), and a 2-bit saturating counter (0 = strong-NT, 1 = weak-NT, 2 = weak-T, 3 = strong-T).
REQ-017 Lookup SHALL be combinational, with zero-cycle latency from fetch_pc_i.
REQ-018 predict_hit_o SHALL be valid && tag match.
REQ-019 predict_taken_o SHALL be predict_hit_o && counter[1].
REQ-020 predict_target_o SHALL be the stored target when predict_taken_o=1, else fetch_pc_i+4 (modulo 2^width_p).
REQ-021 Updates SHALL be written at the clock edge and become visible to lookup on the following cycle.
REQ-022 A lookup and an update to the same index in the same cycle SHALL return the pre-update contents; there is no bypass.
REQ-023 Update, hit case (valid && tag match): the counter SHALL increment (saturating at 3) if update_taken_i=1, else decrement (saturating at 0).
REQ-024 Update, hit case: the target SHALL be overwritten with update_target_i only when update_taken_i=1.
REQ-025 Update, miss case, update_taken_i=1: the entry SHALL be allocated (overwriting any occupant) with valid=1, new tag, target=update_target_i, and counter=3 if update_is_jump_i=1, else 2.
REQ-026 Update, miss case, update_taken_i=0: there SHALL be no state change.
REQ-027 Update, hit case, update_is_jump_i=1: the counter SHALL be forced to 3 regardless of the saturation rule.
REQ-028 hit_count_o SHALL increment by 1 on each rising edge at which predict_hit_o=1 and reset_i=0, wrapping from 0xFFFFFFFF to 0.
REQ-029 update_valid_i=0 SHALL leave all entry state unchanged.

Reset
REQ-030 While reset_i=1 at a rising edge, all valid bits and hit_count_o SHALL clear to 0; target, tag and counter storage need not be reset.
REQ-031 Reset SHALL take priority over a simultaneous update, which SHALL be discarded.
REQ-032 During and after reset, with no updates, the outputs SHALL be predict_hit_o=0, predict_taken_o=0, predict_target_o=fetch_pc_i+4.

Structure
REQ-033 The shared CPU package SHALL hold the 2-bit counter enum (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T) and the BTB entry struct typedef.
REQ-034 The saturating-counter next-state logic SHALL be one combinational sub-module, sat_counter2 (inputs: state, taken, force_strong_taken; output: next state).
REQ-035 The entry array SHALL be flops (no SRAM macro); with defaults the target is 120 to 400 lines of RTL total.

Verification
REQ-036 Reset, then fetch_pc_i=0x100 -> predict_hit_o=0, predict_taken_o=0, predict_target_o=0x104, hit_count_o=0.
REQ-037 Update pc=0x100, taken=1, jump=0, target=0x80; next cycle fetch 0x100 -> hit=1, taken=1, target=0x80; hit_count_o increments.
REQ-038 Starting from REQ-037 state, two not-taken updates at 0x100 -> counter 2 then 1 then 0; fetch 0x100 -> hit=1, taken=0, target=0x104; a third not-taken update leaves the counter at 0.
REQ-039 Alias: after REQ-037, taken update pc=0x140 (same index, different tag for entries_p=16), target=0x200 -> fetch 0x100 misses with target 0x104; fetch 0x140 hits with target 0x200.
REQ-040 Same-cycle lookup and update at 0x100 (taken, target 0x300, empty BTB) -> that cycle hit=0, target 0x104; next cycle hit=1, target 0x300.
REQ-041 Update asserted together with reset_i=1 -> after reset, fetch of that PC misses; a not-taken update on a miss never allocates.
